// File: rtl/mem_stage_if.sv
// Data-memory request/ack bus between the MEM stage and data memory.
// Request fields stay valid while dmem_req is high; rdata is valid with ack.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolve, variable-latency data access with
// upstream stall and timeout, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT    = 16,
  parameter int STALLCNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  valid_in,
  input  logic                  branch_in,
  input  logic                  jump_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  RegWrite_in,
  input  logic                  MemtoReg_in,
  input  logic [31:0]           add_in,
  input  logic [31:0]           alu_in,
  input  logic                  aluzero_in,
  input  logic [31:0]           readdata2_in,
  input  logic [4:0]            regdst_in,
  output logic                  pcsrc,
  output logic [31:0]           branch_target,
  output logic                  stall,
  mem_stage_if.master           bus,
  output logic                  valid_out,
  output logic                  RegWrite_out,
  output logic                  MemtoReg_out,
  output logic [31:0]           memdata_out,
  output logic [31:0]           alu_out,
  output logic [4:0]            regdst_out,
  output logic                  misalign_err,
  output logic                  timeout_err,
  output logic [STALLCNT_W-1:0] stall_count
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WLAST = CW'(TIMEOUT - 1);
  localparam logic [31:0] BADDATA = 32'hDEAD_BEEF;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [CW-1:0] wcnt;

  logic acc;
  logic misalign;
  logic mem_op;
  logic is_load;
  logic req;
  logic stall_c;
  logic expire;
  logic got_data;

  assign pcsrc = valid_in & ((branch_in & aluzero_in) | jump_in);
  assign branch_target = add_in;

  always_comb begin
    acc      = valid_in & (MemRead_in | MemWrite_in);
    misalign = acc & (alu_in[1:0] != 2'b00);
    mem_op   = acc & ~misalign;
    is_load  = MemRead_in & ~MemWrite_in;
    req      = 1'b0;
    stall_c  = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        req     = mem_op;
        stall_c = mem_op & ~bus.dmem_ack;
      end
      WAIT: begin
        req     = 1'b1;
        expire  = ~bus.dmem_ack & (wcnt == WLAST);
        stall_c = ~bus.dmem_ack & ~expire;
      end
    endcase
    // reset drops the request and releases upstream at once
    if (RST) begin
      req     = 1'b0;
      stall_c = 1'b0;
      expire  = 1'b0;
    end
    got_data = req & bus.dmem_ack & is_load;
  end

  assign stall          = stall_c;
  assign bus.dmem_req   = req;
  assign bus.dmem_we    = MemWrite_in;
  assign bus.dmem_addr  = alu_in;
  assign bus.dmem_wdata = readdata2_in;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_op & ~bus.dmem_ack) begin
            state <= WAIT;
            wcnt  <= '0;
          end
        end
        WAIT: begin
          if (bus.dmem_ack | expire) state <= IDLE;
          else wcnt <= wcnt + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_out    <= 1'b0;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= 1'b0;
      memdata_out  <= '0;
      alu_out      <= '0;
      regdst_out   <= '0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      stall_count  <= '0;
    end else begin
      if (stall_c) begin
        valid_out    <= 1'b0;
        RegWrite_out <= 1'b0;
      end else begin
        valid_out    <= valid_in;
        RegWrite_out <= RegWrite_in & ~misalign & ~expire;
        MemtoReg_out <= MemtoReg_in;
        alu_out      <= alu_in;
        regdst_out   <= regdst_in;
        memdata_out  <= expire   ? BADDATA :
                        got_data ? bus.dmem_rdata : '0;
      end
      if (misalign) misalign_err <= 1'b1;
      if (expire) timeout_err <= 1'b1;
      if (stall_c && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: ALU pass-through, waited and
// zero-wait accesses, branch resolve, misalign, timeout, reset in WAIT.
module tb_mem_stage;
  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        valid_in, branch_in, jump_in;
  logic        MemRead_in, MemWrite_in, RegWrite_in, MemtoReg_in;
  logic [31:0] add_in, alu_in, readdata2_in;
  logic        aluzero_in;
  logic [4:0]  regdst_in;
  logic        pcsrc, stall, valid_out, RegWrite_out, MemtoReg_out;
  logic [31:0] branch_target, memdata_out, alu_out;
  logic [4:0]  regdst_out;
  logic        misalign_err, timeout_err;
  logic [15:0] stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(TO), .STALLCNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .valid_in(valid_in), .branch_in(branch_in), .jump_in(jump_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .add_in(add_in), .alu_in(alu_in), .aluzero_in(aluzero_in),
    .readdata2_in(readdata2_in), .regdst_in(regdst_in),
    .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
    .bus(bus.master),
    .valid_out(valid_out), .RegWrite_out(RegWrite_out),
    .MemtoReg_out(MemtoReg_out), .memdata_out(memdata_out),
    .alu_out(alu_out), .regdst_out(regdst_out),
    .misalign_err(misalign_err), .timeout_err(timeout_err),
    .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 0; branch_in = 0; jump_in = 0;
    MemRead_in = 0; MemWrite_in = 0; RegWrite_in = 0; MemtoReg_in = 0;
    add_in = 0; alu_in = 0; aluzero_in = 0; readdata2_in = 0;
    regdst_in = 0;
    bus.dmem_ack = 0; bus.dmem_rdata = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] rd);
    idle_in();
    valid_in = 1; MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1;
    alu_in = a; regdst_in = rd;
  endtask

  int n;
  int reqs;

  initial begin
    idle_in();
    step(); step();
    chk("rst valid_out", 32'(valid_out), 0);
    chk("rst stall_count", 32'(stall_count), 0);
    chk("rst errs", {30'd0, misalign_err, timeout_err}, 0);
    chk("rst req", 32'(bus.dmem_req), 0);
    RST = 0;
    step();

    // ALU op passes straight through
    valid_in = 1; RegWrite_in = 1; alu_in = 32'h10; regdst_in = 5;
    #1 chk("alu stall", 32'(stall), 0);
    chk("alu req", 32'(bus.dmem_req), 0);
    step();
    chk("alu valid_out", 32'(valid_out), 1);
    chk("alu alu_out", alu_out, 32'h10);
    chk("alu regdst", 32'(regdst_out), 5);
    chk("alu regwrite", 32'(RegWrite_out), 1);

    // load acked 3 cycles after request
    load(32'h100, 7);
    reqs = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        bus.dmem_ack = 1; bus.dmem_rdata = 32'hCAFEF00D;
      end
      #1;
      if (bus.dmem_req) reqs++;
      if (c == 1) chk("ld bubble", 32'(valid_out), 0);
      chk($sformatf("ld stall c%0d", c), 32'(stall), (c < 3) ? 1 : 0);
      step();
    end
    chk("ld req cycles", reqs, 4);
    chk("ld memdata", memdata_out, 32'hCAFEF00D);
    chk("ld valid_out", 32'(valid_out), 1);
    chk("ld stall_count", 32'(stall_count), 3);
    chk("ld regwrite", 32'(RegWrite_out), 1);

    // zero-wait store
    idle_in();
    valid_in = 1; MemWrite_in = 1; alu_in = 32'h40;
    readdata2_in = 32'h12345678; bus.dmem_ack = 1;
    #1 chk("st req", 32'(bus.dmem_req), 1);
    chk("st we", 32'(bus.dmem_we), 1);
    chk("st addr", bus.dmem_addr, 32'h40);
    chk("st wdata", bus.dmem_wdata, 32'h12345678);
    chk("st stall", 32'(stall), 0);
    step();
    chk("st regwrite", 32'(RegWrite_out), 0);
    chk("st valid_out", 32'(valid_out), 1);
    chk("st memdata", memdata_out, 0);
    chk("st stall_count", 32'(stall_count), 3);

    // branch / jump resolve
    idle_in();
    valid_in = 1; branch_in = 1; aluzero_in = 1; add_in = 32'h00400020;
    #1 chk("br taken", 32'(pcsrc), 1);
    chk("br target", branch_target, 32'h00400020);
    aluzero_in = 0;
    #1 chk("br not taken", 32'(pcsrc), 0);
    branch_in = 0; jump_in = 1;
    #1 chk("jump", 32'(pcsrc), 1);
    valid_in = 0;
    #1 chk("jump invalid", 32'(pcsrc), 0);
    step();

    // ack with no request is ignored
    idle_in();
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h55AA55AA;
    step();
    chk("stray ack valid", 32'(valid_out), 0);
    chk("stray ack data", memdata_out, 0);

    // misaligned load
    load(32'h102, 9);
    #1 chk("mis req", 32'(bus.dmem_req), 0);
    chk("mis stall", 32'(stall), 0);
    step();
    chk("mis err", 32'(misalign_err), 1);
    chk("mis valid_out", 32'(valid_out), 1);
    chk("mis regwrite", 32'(RegWrite_out), 0);
    chk("mis no timeout", 32'(timeout_err), 0);

    // load never acked -> timeout
    load(32'h200, 3);
    n = 0;
    #1;
    while (stall && n < 40) begin
      n++;
      step();
    end
    chk("to stall cycles", n, TO);
    chk("to req at release", 32'(bus.dmem_req), 1);
    step();
    chk("to err", 32'(timeout_err), 1);
    chk("to memdata", memdata_out, 32'hDEADBEEF);
    chk("to regwrite", 32'(RegWrite_out), 0);
    chk("to valid_out", 32'(valid_out), 1);
    chk("to stall_count", 32'(stall_count), 3 + TO);

    // reset in the middle of WAIT
    load(32'h300, 4);
    step(); step();
    #1 chk("w8 stall", 32'(stall), 1);
    RST = 1;
    #1 chk("rstw req", 32'(bus.dmem_req), 0);
    chk("rstw stall", 32'(stall), 0);
    chk("rstw outs", {valid_out, RegWrite_out, misalign_err, timeout_err}, 0);
    chk("rstw memdata", memdata_out, 0);
    chk("rstw stall_count", 32'(stall_count), 0);
    step();
    RST = 0;
    #1 chk("post req", 32'(bus.dmem_req), 1);
    chk("post stall", 32'(stall), 1);
    step();
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h0BADF00D;
    #1 chk("post ack stall", 32'(stall), 0);
    step();
    chk("post memdata", memdata_out, 32'h0BADF00D);
    chk("post valid_out", 32'(valid_out), 1);
    chk("post regdst", 32'(regdst_out), 4);
    chk("post stall_count", 32'(stall_count), 1);

    idle_in();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEMORY stage of the 5-stage MIPS pipeline; sits directly downstream of EX and consumes the EX/MEM register outputs.
- Resolves branch/jump to the PC mux.
- Runs load/store accesses on a variable-latency data-memory handshake, stalling upstream until the memory acknowledges.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- TIMEOUT, 16, max cycles WAIT may last before forced completion with error.
- STALLCNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- valid_in  in  1  EX/MEM holds a real instruction.
- branch_in  in  1  branch control from EX/MEM.
- jump_in  in  1  jump control from EX/MEM.
- MemRead_in  in  1  load.
- MemWrite_in  in  1  store.
- RegWrite_in  in  1  register write enable.
- MemtoReg_in  in  1  write-back source select.
- add_in  in  32  branch/jump target.
- alu_in  in  32  ALU result / byte address.
- aluzero_in  in  1  ALU zero flag.
- readdata2_in  in  32  store data.
- regdst_in  in  5  destination register.
- pcsrc  out  1  load branch_target into PC.
- branch_target  out  32  PC target.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- dmem_req  out  1  memory request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  byte address.
- dmem_wdata  out  32  write data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete.
- valid_out  out  1  MEM/WB holds a real instruction.
- RegWrite_out  out  1  MEM/WB.
- MemtoReg_out  out  1  MEM/WB.
- memdata_out  out  32  MEM/WB load data.
- alu_out  out  32  MEM/WB ALU result.
- regdst_out  out  5  MEM/WB destination register.
- misalign_err  out  1  sticky.
- timeout_err  out  1  sticky.
- stall_count  out  STALLCNT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, immediate): state=IDLE; all registered outputs 0; dmem_req, stall and pcsrc go 0 combinationally from state/valid.
- Branch/jump, combinational:
  - pcsrc = valid_in & ((branch_in & aluzero_in) | jump_in).
  - branch_target = add_in.
  - Never depends on FSM state.
- Memory op: mem_op = valid_in & (MemRead_in | MemWrite_in) & (alu_in[1:0]==0).
- Both MemRead_in and MemWrite_in set: treated as a store; no error.
- Misaligned op (valid_in, MemRead_in|MemWrite_in, alu_in[1:0]!=0):
  - No request issued; misalign_err set (sticky until RST).
  - Instruction retires in 1 cycle with RegWrite_out forced 0.
- FSM, two states:
  - IDLE: dmem_req = mem_op.
    - If dmem_ack in the same cycle: zero-wait completion, stall=0, MEM/WB loads.
    - Otherwise: stall=1, clear wait counter, go to WAIT.
  - WAIT: dmem_req=1; dmem_addr/we/wdata driven from the held EX/MEM inputs, which upstream holds stable because stall=1.
    - On dmem_ack: stall=0 this cycle, MEM/WB loads, go to IDLE.
    - Otherwise: stall=1, counter++.
    - Counter reaching TIMEOUT-1 without ack: complete as if acked with memdata=32'hDEADBEEF, RegWrite_out forced 0, timeout_err set (sticky), go to IDLE.
- dmem_we = MemWrite_in; dmem_addr = alu_in; dmem_wdata = readdata2_in. Valid only while dmem_req=1.
- MEM/WB register, rising edge:
  - When stall=0: valid_out<=valid_in; controls, alu, regdst copied; memdata_out<=dmem_rdata if ack for a load, else 0.
  - When stall=1: valid_out<=0 (bubble), RegWrite_out<=0, other fields hold.
- Latency: non-memory instruction and zero-wait access reach MEM/WB 1 cycle later. An access acked N cycles after request stalls N cycles.
- stall_count: +1 each cycle stall=1; saturates at all-ones.
- Ack while in IDLE with no request: ignored.
- RST during WAIT: request dropped immediately; no MEM/WB update.

Test Plan:
- ALU op, valid_in=1, alu_in=0x00000010, RegWrite_in=1, regdst_in=5 -> next cycle valid_out=1, alu_out=0x10, regdst_out=5, stall never 1.
- Load at alu_in=0x100, ack 3 cycles after req, rdata=0xCAFEF00D -> stall=1 for 3 cycles, dmem_req held 4 cycles, then memdata_out=0xCAFEF00D, valid_out=1, stall_count=3.
- Store at 0x40, data 0x12345678, ack same cycle -> dmem_req=1, dmem_we=1, wdata=0x12345678 for 1 cycle, stall=0, RegWrite_out=0.
- Branch with aluzero_in=1, add_in=0x00400020 -> pcsrc=1, branch_target=0x00400020 same cycle; aluzero_in=0 -> pcsrc=0. jump_in=1 -> pcsrc=1.
- Load at 0x102 -> no dmem_req, misalign_err=1, valid_out=1 with RegWrite_out=0. Load with no ack for TIMEOUT cycles -> timeout_err=1, memdata_out=0xDEADBEEF, stall released.
- RST pulse mid-WAIT -> dmem_req and stall drop immediately, all outputs 0. After release, a new load completes normally.
